game_state_manager: RTL and testbench
=====================================

Name: game_state_manager

Overview:
- Consumes the per-frame single-hit pulses and level collision signals from the collision/game controller.
- Maintains the lives count, a 4-digit BCD score, and the top-level game FSM: idle, play, invulnerability after a hit, level done, game over.
- Drives the score/lives display, player visibility blinking, and the movement enable used by the player and object controllers.

Parameters:
- INIT_LIVES, 3, lives loaded on new game (1..MAX_LIVES).
- MAX_LIVES, 5, potion saturation limit (≤7).
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255).
- BLINK_FRAMES, 4, frames per half-period of the visibility blink during invulnerability (1..15).
- MONEY_POINTS, 5, score added per money pulse.
- MINE_POINTS, 2, score added per landmine pulse.
- WALL_POINTS, 1, score added per wall pulse.
- Constraint: MONEY_POINTS + MINE_POINTS + WALL_POINTS ≤ 9.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_game  in  1  one-cycle pulse from key debouncer
- hit_flames  in  1  single pulse: player hit by flames
- hit_potion  in  1  single pulse: potion collected
- hit_money  in  1  single pulse: money collected
- hit_mine  in  1  single pulse: flames destroyed a mine
- hit_wall  in  1  single pulse: flames destroyed a wall
- reached_sewer  in  1  level signal: player overlaps sewer
- game_state  out  3  0=IDLE 1=PLAY 2=INVULN 3=LEVEL_DONE 4=GAME_OVER
- lives  out  3  current lives
- score_bcd  out  16  4 BCD digits, [15:12] most significant
- player_visible  out  1  0 during blink-off phase
- play_enable  out  1  1 in PLAY or INVULN
- game_over  out  1  1 in GAME_OVER
- level_done  out  1  1 in LEVEL_DONE

Behaviour:
- Reset (resetN low, asynchronous): state IDLE, lives=INIT_LIVES, score_bcd=0, invuln counter=0, blink counter=0, player_visible=1. Outputs follow as decoded: play_enable=0, game_over=0, level_done=0.
- All outputs are registered or decoded from registers only. Every input takes effect on the clk edge where it is sampled high, so outputs update 1 cycle later.
- IDLE: start_game -> PLAY. Lives=INIT_LIVES, score=0.
- PLAY:
  - hit_flames, lives>1, no potion -> lives-1, go to INVULN. Load invuln counter with INVULN_FRAMES, clear blink counter.
  - hit_flames, lives==1, no potion -> lives=0, go to GAME_OVER.
  - hit_flames and hit_potion in the same cycle -> lives unchanged, go to INVULN.
  - hit_potion alone -> lives=min(lives+1, MAX_LIVES).
- INVULN:
  - hit_flames is ignored. hit_potion is handled as in PLAY.
  - On each startOfFrame, the counter decrements. When a decrement reaches 0, go to PLAY.
  - The blink counter counts frames. player_visible toggles every BLINK_FRAMES frames, starting at 0 on entry.
  - player_visible=1 in every other state.
- reached_sewer high in PLAY or INVULN -> LEVEL_DONE. This has priority over hit_flames in the same cycle.
- LEVEL_DONE: score and lives frozen. start_game -> PLAY with score and lives kept and invuln cleared.
- GAME_OVER: score held for display. start_game -> PLAY with lives=INIT_LIVES and score=0.
- start_game in PLAY/INVULN is ignored.
- Score:
  - Accepted only in PLAY/INVULN.
  - In one cycle, increment = MONEY_POINTS·hit_money + MINE_POINTS·hit_mine + WALL_POINTS·hit_wall. All simultaneous pulses are counted.
  - BCD add with per-digit carry (digit >9 -> subtract 10, carry 1).
  - Saturates at 9999: if a carry out of digit 3 would occur, score=9999.
  - Score pulses in the same cycle as a state transition are still added if the current state is PLAY/INVULN.
- Score and lives both update in the same cycle when pulses coincide.
- Reset mid-game returns to IDLE immediately.

Test Plan:
- Reset, start_game, 3 hit_money pulses on separate cycles -> score_bcd=16'h0015, state PLAY, lives=3.
- hit_money+hit_mine+hit_wall in one cycle from score 16'h0095 -> 16'h0103. Score 16'h9998 + hit_money -> 16'h9999.
- hit_flames at lives=3 -> lives=2, state INVULN. A second hit_flames 10 frames later -> lives stays 2. player_visible toggles every 4 frames. PLAY after exactly 60 startOfFrame pulses.
- Lives=1, hit_flames -> lives=0, GAME_OVER, game_over=1, score held. start_game -> PLAY, lives=3, score=0.
- Lives=1, hit_flames+hit_potion in the same cycle -> lives=1, INVULN. At lives=5, hit_potion -> lives=5.
- reached_sewer and hit_flames in the same cycle -> LEVEL_DONE, lives unchanged. hit_money ignored. start_game -> PLAY, score kept. Assert resetN mid-INVULN -> IDLE, lives=3, score=0.

Source files
------------

// File: rtl/game_state_manager.sv
// Top-level game controller: lives, 4-digit BCD score, and the
// idle/play/invulnerable/level-done/game-over state machine. It consumes
// single-cycle hit pulses and the sewer level signal. It drives the display
// values, the player blink, and the movement enable.
// Handshake: there is no valid/ready pair. Each input pulse counts on the
// rising clk edge where it is sampled high. The result is visible on the
// outputs from that edge on, which is one cycle after the pulse was driven.
module game_state_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4,
    parameter int MONEY_POINTS  = 5,
    parameter int MINE_POINTS   = 2,
    parameter int WALL_POINTS   = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_game,
    input  logic        hit_flames,
    input  logic        hit_potion,
    input  logic        hit_money,
    input  logic        hit_mine,
    input  logic        hit_wall,
    input  logic        reached_sewer,
    output logic [2:0]  game_state,
    output logic [2:0]  lives,
    output logic [15:0] score_bcd,
    output logic        player_visible,
    output logic        play_enable,
    output logic        game_over,
    output logic        level_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PLAY       = 3'd1,
        S_INVULN     = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [2:0] LP_INIT_LIVES = 3'(INIT_LIVES);
    localparam logic [2:0] LP_MAX_LIVES  = 3'(MAX_LIVES);
    localparam logic [7:0] LP_INVULN     = 8'(INVULN_FRAMES);
    localparam logic [3:0] LP_BLINK_LAST = 4'(BLINK_FRAMES - 1);
    localparam logic [3:0] LP_MONEY      = 4'(MONEY_POINTS);
    localparam logic [3:0] LP_MINE       = 4'(MINE_POINTS);
    localparam logic [3:0] LP_WALL       = 4'(WALL_POINTS);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_lives;
    logic [15:0] r_score;
    logic [7:0]  r_invuln_cnt;
    logic [3:0]  r_blink_cnt;
    logic        r_visible;

    logic        w_active;
    logic        w_flames_eff;
    logic        w_restart_new;
    logic [2:0]  w_lives_inc;
    logic [3:0]  w_inc;
    logic [4:0]  w_d0, w_d1, w_d2, w_d3;
    logic [15:0] w_score_sum;

    // Adds a value of at most 9 to one BCD digit. Returns {carry, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] d, input logic [3:0] a);
        logic [4:0] s;
        logic [4:0] t;
        s = {1'b0, d} + {1'b0, a};
        t = s - 5'd10;
        if (s > 5'd9) return {1'b1, t[3:0]};
        return s;
    endfunction

    assign w_active      = (r_state == S_PLAY) || (r_state == S_INVULN);
    // The sewer overrides a flame hit in the same cycle.
    assign w_flames_eff  = hit_flames && !reached_sewer;
    assign w_restart_new = start_game && ((r_state == S_IDLE) || (r_state == S_GAME_OVER));
    assign w_lives_inc   = (r_lives >= LP_MAX_LIVES) ? LP_MAX_LIVES : r_lives + 3'd1;

    assign w_inc = (hit_money ? LP_MONEY : 4'd0) + (hit_mine ? LP_MINE : 4'd0)
                 + (hit_wall ? LP_WALL : 4'd0);
    assign w_d0  = bcd_digit_add(r_score[3:0],   w_inc);
    assign w_d1  = bcd_digit_add(r_score[7:4],   {3'd0, w_d0[4]});
    assign w_d2  = bcd_digit_add(r_score[11:8],  {3'd0, w_d1[4]});
    assign w_d3  = bcd_digit_add(r_score[15:12], {3'd0, w_d2[4]});
    // A carry out of the top digit saturates the score at 9999.
    assign w_score_sum = w_d3[4] ? 16'h9999 : {w_d3[3:0], w_d2[3:0], w_d1[3:0], w_d0[3:0]};

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (start_game) w_next_state = S_PLAY;
            S_PLAY: begin
                if (reached_sewer) w_next_state = S_LEVEL_DONE;
                else if (hit_flames) begin
                    if (hit_potion || (r_lives > 3'd1)) w_next_state = S_INVULN;
                    else                                w_next_state = S_GAME_OVER;
                end
            end
            S_INVULN: begin
                if (reached_sewer) w_next_state = S_LEVEL_DONE;
                else if (startOfFrame && (r_invuln_cnt <= 8'd1)) w_next_state = S_PLAY;
            end
            S_LEVEL_DONE: if (start_game) w_next_state = S_PLAY;
            S_GAME_OVER:  if (start_game) w_next_state = S_PLAY;
            default:      w_next_state = S_IDLE;
        endcase
    end

    // Output decode from registers only.
    always_comb begin
        game_state     = r_state;
        lives          = r_lives;
        score_bcd      = r_score;
        player_visible = r_visible;
        play_enable    = w_active;
        game_over      = (r_state == S_GAME_OVER);
        level_done     = (r_state == S_LEVEL_DONE);
    end

    // Lives: reload on a new game, flame damage in PLAY, potion with saturation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_lives <= LP_INIT_LIVES;
        else if (w_restart_new) r_lives <= LP_INIT_LIVES;
        else if (r_state == S_PLAY) begin
            if (w_flames_eff && !hit_potion)      r_lives <= r_lives - 3'd1;
            else if (hit_potion && !w_flames_eff) r_lives <= w_lives_inc;
        end else if (r_state == S_INVULN && hit_potion) r_lives <= w_lives_inc;
    end

    // Score: cleared on a new game, accumulates only while play is active.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)            r_score <= 16'h0000;
        else if (w_restart_new) r_score <= 16'h0000;
        else if (w_active)      r_score <= w_score_sum;
    end

    // Invulnerability timer and blink phase. Both are loaded on entry, run on
    // frame pulses while INVULN persists, and are cleared in any other state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_invuln_cnt <= 8'd0;
            r_blink_cnt  <= 4'd0;
            r_visible    <= 1'b1;
        end else if (r_state == S_PLAY && w_next_state == S_INVULN) begin
            r_invuln_cnt <= LP_INVULN;
            r_blink_cnt  <= 4'd0;
            r_visible    <= 1'b0;
        end else if (r_state == S_INVULN && w_next_state == S_INVULN) begin
            if (startOfFrame) begin
                r_invuln_cnt <= r_invuln_cnt - 8'd1;
                if (r_blink_cnt == LP_BLINK_LAST) begin
                    r_blink_cnt <= 4'd0;
                    r_visible   <= ~r_visible;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 4'd1;
                end
            end
        end else begin
            r_invuln_cnt <= 8'd0;
            r_blink_cnt  <= 4'd0;
            r_visible    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_game_state_manager.sv
// Bench for game_state_manager: directed scenarios followed by random play.
// A reference model works in plain integers. It tracks the decimal score,
// the frames left and the frames elapsed. Every driven cycle pushes the
// expected output word, and a monitor pops and compares it after the edge.
module tb_game_state_manager;
    localparam int INIT_LIVES    = 3;
    localparam int MAX_LIVES     = 5;
    localparam int INVULN_FRAMES = 60;
    localparam int BLINK_FRAMES  = 4;
    localparam int MONEY_POINTS  = 5;
    localparam int MINE_POINTS   = 2;
    localparam int WALL_POINTS   = 1;
    localparam int W = 26;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0, start_game = 1'b0, hit_flames = 1'b0, hit_potion = 1'b0;
    logic hit_money = 1'b0, hit_mine = 1'b0, hit_wall = 1'b0, reached_sewer = 1'b0;
    logic [2:0]  game_state;
    logic [2:0]  lives;
    logic [15:0] score_bcd;
    logic        player_visible, play_enable, game_over, level_done;

    game_state_manager #(
        .INIT_LIVES(INIT_LIVES), .MAX_LIVES(MAX_LIVES), .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES), .MONEY_POINTS(MONEY_POINTS),
        .MINE_POINTS(MINE_POINTS), .WALL_POINTS(WALL_POINTS)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
        .hit_flames(hit_flames), .hit_potion(hit_potion), .hit_money(hit_money),
        .hit_mine(hit_mine), .hit_wall(hit_wall), .reached_sewer(reached_sewer),
        .game_state(game_state), .lives(lives), .score_bcd(score_bcd),
        .player_visible(player_visible), .play_enable(play_enable),
        .game_over(game_over), .level_done(level_done)
    );

    // Clock and counters.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state: 0 idle, 1 play, 2 invuln, 3 level done, 4 game over.
    int m_state, m_lives, m_score, m_inv_left, m_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = INIT_LIVES; m_score = 0; m_inv_left = 0; m_frames = 0;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [W-1:0] model_word();
        logic vis;
        vis = (m_state == 2) ? (((m_frames / BLINK_FRAMES) % 2) == 1) : 1'b1;
        return {3'(m_state), 3'(m_lives), to_bcd(m_score), vis,
                (m_state == 1 || m_state == 2), (m_state == 4), (m_state == 3)};
    endfunction

    task automatic enter_invuln();
        m_state = 2; m_inv_left = INVULN_FRAMES; m_frames = 0;
    endtask

    task automatic potion_gain();
        m_lives = (m_lives + 1 > MAX_LIVES) ? MAX_LIVES : m_lives + 1;
    endtask

    task automatic model_step(input bit sof, st, fl, po, mo, mi, wa, sw);
        int inc;
        inc = MONEY_POINTS * int'(mo) + MINE_POINTS * int'(mi) + WALL_POINTS * int'(wa);
        if (m_state == 1 || m_state == 2)
            m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
        case (m_state)
            0: if (st) begin m_state = 1; m_lives = INIT_LIVES; m_score = 0; end
            1: begin
                if (po && !(fl && !sw)) potion_gain();
                if (sw) m_state = 3;
                else if (fl) begin
                    if (po) enter_invuln();
                    else if (m_lives > 1) begin m_lives--; enter_invuln(); end
                    else begin m_lives = 0; m_state = 4; end
                end
            end
            2: begin
                if (po) potion_gain();
                if (sw) m_state = 3;
                else if (sof) begin
                    m_inv_left--; m_frames++;
                    if (m_inv_left == 0) m_state = 1;
                end
            end
            3: if (st) m_state = 1;
            4: if (st) begin m_state = 1; m_lives = INIT_LIVES; m_score = 0; end
            default: m_state = 0;
        endcase
    endtask

    // Driver: called on a falling edge, returns on the next falling edge.
    task automatic drive(input bit sof, st, fl, po, mo, mi, wa, sw);
        startOfFrame = sof; start_game = st; hit_flames = fl; hit_potion = po;
        hit_money = mo; hit_mine = mi; hit_wall = wa; reached_sewer = sw;
        model_step(sof, st, fl, po, mo, mi, wa, sw);
        exp_q.push_back(model_word());
        @(negedge clk);
    endtask

    task automatic idle();  drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic frame(); drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic start(); drive(0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic money(); drive(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic flame(); drive(0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic potion(); drive(0, 0, 0, 1, 0, 0, 0, 0); endtask

    task automatic wait_out_invuln();
        for (int f = 0; f < INVULN_FRAMES; f++) frame();
    endtask

    // Monitor / scoreboard: compare the DUT against the oldest expectation after every edge.
    always @(posedge clk) begin
        logic [W-1:0] exp_w;
        #1;
        if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("cycle_outputs",
                  {game_state, lives, score_bcd, player_visible, play_enable, game_over, level_done},
                  exp_w);
        end
    end

    initial begin
        model_reset();
        #12;
        check("reset_outputs",
              {game_state, lives, score_bcd, player_visible, play_enable, game_over, level_done},
              {3'd0, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        resetN = 1'b1;

        // Start and three separate money pulses.
        start();
        for (int i = 0; i < 3; i++) begin money(); idle(); end
        check("score_0015", score_bcd, 16'h0015);
        check("state_play", game_state, 3'd1);
        check("lives_3", lives, 3'd3);

        // Carry across digits with simultaneous pulses.
        for (int i = 0; i < 16; i++) money();
        check("score_0095", score_bcd, 16'h0095);
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        check("score_0103", score_bcd, 16'h0103);

        // Climb to 9998, then saturate.
        while (m_score + 8 <= 9998) drive(0, 0, 0, 0, 1, 1, 1, 0);
        while (m_score < 9998) begin
            if (9998 - m_score >= 5)      money();
            else if (9998 - m_score >= 2) drive(0, 0, 0, 0, 0, 1, 0, 0);
            else                          drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        check("score_9998", score_bcd, 16'h9998);
        money();
        check("score_sat_9999", score_bcd, 16'h9999);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("score_stays_9999", score_bcd, 16'h9999);

        // Non-fatal hit, blink phase, ignored second hit, exit after 60 frames.
        flame();
        check("hit_lives_2", lives, 3'd2);
        check("hit_state_invuln", game_state, 3'd2);
        check("invuln_visible_0", player_visible, 1'b0);
        for (int f = 1; f <= INVULN_FRAMES; f++) begin
            frame();
            if (f == 3)  check("vis_frame3", player_visible, 1'b0);
            if (f == 4)  check("vis_frame4", player_visible, 1'b1);
            if (f == 8)  check("vis_frame8", player_visible, 1'b0);
            if (f == 10) begin flame(); check("second_hit_lives_2", lives, 3'd2); end
            if (f == 59) check("still_invuln_59", game_state, 3'd2);
            if (f == 60) check("play_after_60", game_state, 3'd1);
            if (f < INVULN_FRAMES) idle();
        end

        // Down to one life, shielded hit, fatal hit, restart.
        flame();
        wait_out_invuln();
        check("lives_1", lives, 3'd1);
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        check("flame_potion_lives_1", lives, 3'd1);
        check("flame_potion_invuln", game_state, 3'd2);
        wait_out_invuln();
        flame();
        check("fatal_lives_0", lives, 3'd0);
        check("fatal_game_over", game_over, 1'b1);
        money();
        check("game_over_score_held", score_bcd, 16'h9999);
        start();
        check("restart_state", game_state, 3'd1);
        check("restart_lives", lives, 3'd3);
        check("restart_score", score_bcd, 16'h0000);

        // Potion saturation.
        potion(); potion();
        check("potion_lives_5", lives, 3'd5);
        potion();
        check("potion_sat_5", lives, 3'd5);

        // Sewer beats flames, level done freezes, resume keeps score.
        money(); money();
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        check("sewer_level_done", level_done, 1'b1);
        check("sewer_lives_kept", lives, 3'd5);
        check("sewer_no_play_enable", play_enable, 1'b0);
        money();
        check("level_done_score_frozen", score_bcd, 16'h0010);
        start();
        check("resume_play", game_state, 3'd1);
        check("resume_score", score_bcd, 16'h0010);

        // Asynchronous reset in the middle of invulnerability.
        flame();
        for (int f = 0; f < 5; f++) frame();
        startOfFrame = 0; start_game = 0; hit_flames = 0; hit_potion = 0;
        hit_money = 0; hit_mine = 0; hit_wall = 0; reached_sewer = 0;
        #1 resetN = 1'b0;
        #1;
        check("async_reset_outputs",
              {game_state, lives, score_bcd, player_visible, play_enable, game_over, level_done},
              {3'd0, 3'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        model_reset();
        #1 resetN = 1'b1;
        @(negedge clk);

        // Random play against the reference model.
        start();
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) == 0,  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,  $urandom_range(0, 199) == 0);
        end
        idle(); idle();
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
